// File: rtl/level_gen_if.sv
// level_gen_if: request pulses in, reconstructed level and status out.
// Handshake: there is no valid/ready pair. rise_i and fall_i are single-cycle
// request pulses, each sampled on the posedge of clk. Every output is a
// registered status that updates on the posedge after the input that caused it.
interface level_gen_if;
   logic       rise_i;
   logic       fall_i;
   logic       level_o;
   logic       hold_o;
   logic       pend_o;
   logic       drop_o;
   logic       conflict_o;
   logic [7:0] edge_cnt_o;

   // Upstream event decoder side
   modport master (
      output rise_i, fall_i,
      input  level_o, hold_o, pend_o, drop_o, conflict_o, edge_cnt_o
   );

   // level_gen side
   modport slave (
      input  rise_i, fall_i,
      output level_o, hold_o, pend_o, drop_o, conflict_o, edge_cnt_o
   );
endinterface

// File: rtl/level_gen.sv
// level_gen: rebuilds a level from rise/fall event pulses while enforcing
// minimum high and low times. A request for the opposite level that arrives
// inside a minimum-time window is held pending and applied at window expiry.
// Optional macro LEVEL_GEN_STATS_EN builds a saturating 8-bit transition
// counter on edge_cnt_o; without it edge_cnt_o is tied to zero.
// MIN_HIGH and MIN_LOW must be >= 1 and fit in CNT_W bits.
module level_gen #(
   parameter int MIN_HIGH = 4,
   parameter int MIN_LOW  = 4,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   level_gen_if.slave bus,
   output logic [1:0] state_dbg_o
);

   typedef enum logic [1:0] {
      LOW_IDLE  = 2'd0,
      HIGH_HOLD = 2'd1,
      HIGH_IDLE = 2'd2,
      LOW_HOLD  = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
   localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             drop_q, drop_d;
   logic             conflict_q, conflict_d;
   logic             level_q, level_d;

   logic rise_req;
   logic fall_req;
   logic cnt_zero;

   // Simultaneous rise and fall cancel each other: neither is seen as a request.
   assign rise_req = bus.rise_i & ~bus.fall_i;
   assign fall_req = bus.fall_i & ~bus.rise_i;
   assign cnt_zero = (cnt_q == '0);

   // Next-state, hold counter, pending flag and event pulses.
   // A conflict only suppresses the requests; the hold timer keeps running.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      drop_d     = 1'b0;
      conflict_d = bus.rise_i & bus.fall_i;
      case (state_q)
         LOW_IDLE: begin
            if (rise_req) begin
               state_d = HIGH_HOLD;
               cnt_d   = HIGH_LOAD;
            end else if (fall_req) begin
               drop_d = 1'b1;
            end
         end
         HIGH_IDLE: begin
            if (fall_req) begin
               state_d = LOW_HOLD;
               cnt_d   = LOW_LOAD;
            end else if (rise_req) begin
               drop_d = 1'b1;
            end
         end
         HIGH_HOLD: begin
            if (cnt_zero) begin
               // Window expires: a pending or same-cycle fall flips the level.
               drop_d = rise_req;
               pend_d = 1'b0;
               if (pend_q | fall_req) begin
                  state_d = LOW_HOLD;
                  cnt_d   = LOW_LOAD;
               end else begin
                  state_d = HIGH_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (fall_req) begin
                  pend_d = 1'b1;
               end else if (rise_req) begin
                  pend_d = 1'b0;
                  drop_d = 1'b1;
               end
            end
         end
         LOW_HOLD: begin
            if (cnt_zero) begin
               drop_d = fall_req;
               pend_d = 1'b0;
               if (pend_q | rise_req) begin
                  state_d = HIGH_HOLD;
                  cnt_d   = HIGH_LOAD;
               end else begin
                  state_d = LOW_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (rise_req) begin
                  pend_d = 1'b1;
               end else if (fall_req) begin
                  pend_d = 1'b0;
                  drop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = LOW_IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
         end
      endcase
      level_d = (state_d == HIGH_HOLD) || (state_d == HIGH_IDLE);
   end

   // State and status registers; reset drops the level with no low window.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= LOW_IDLE;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         drop_q     <= 1'b0;
         conflict_q <= 1'b0;
         level_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         drop_q     <= drop_d;
         conflict_q <= conflict_d;
         level_q    <= level_d;
      end
   end

   assign bus.level_o    = level_q;
   assign bus.hold_o     = (state_q == HIGH_HOLD) || (state_q == LOW_HOLD);
   assign bus.pend_o     = pend_q;
   assign bus.drop_o     = drop_q;
   assign bus.conflict_o = conflict_q;
   assign state_dbg_o    = state_q;

`ifdef LEVEL_GEN_STATS_EN
   logic [7:0] edge_cnt_q;

   // Count level transitions, saturating at 255.
   always_ff @(posedge clk) begin
      if (reset) begin
         edge_cnt_q <= 8'd0;
      end else if ((level_d != level_q) && (edge_cnt_q != 8'hFF)) begin
         edge_cnt_q <= edge_cnt_q + 8'd1;
      end
   end

   assign bus.edge_cnt_o = edge_cnt_q;
`else
   assign bus.edge_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_level_gen.sv
// tb_level_gen: directed scenarios for level_gen with MIN_HIGH=3, MIN_LOW=2.
// Each row drives one cycle of inputs and pushes the outputs expected after
// the following posedge; the row is popped and compared at the negedge.
// Output vector layout: {level, hold, pend, drop, conflict, edge_cnt[7:0]}.
module tb_level_gen;

   logic       clk;
   logic       reset;
   logic [1:0] state_dbg;
   int         total;
   int         bad;
   logic [12:0] exp_q[$];

`ifdef LEVEL_GEN_STATS_EN
   localparam logic [7:0] EDGE_MASK = 8'hFF;
`else
   localparam logic [7:0] EDGE_MASK = 8'h00;
`endif

   level_gen_if bus ();

   level_gen #(
      .MIN_HIGH (3),
      .MIN_LOW  (2),
      .CNT_W    (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .state_dbg_o (state_dbg)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   // Row = {rst, rise, fall, flags[4:0], edge[7:0]}
   function automatic logic [15:0] row(input logic rst, input logic r, input logic f,
                                       input logic [4:0] flags, input int edges);
      return {rst, r, f, flags, 8'(edges)};
   endfunction

   function automatic logic [12:0] observe();
      return {bus.level_o, bus.hold_o, bus.pend_o, bus.drop_o, bus.conflict_o, bus.edge_cnt_o};
   endfunction

   // Drive one cycle of inputs and queue the outputs expected after the edge.
   task automatic drive(input logic [15:0] rw);
      reset      = rw[15];
      bus.rise_i = rw[14];
      bus.fall_i = rw[13];
      exp_q.push_back({rw[12:8], rw[7:0] & EDGE_MASK});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [15:0] rows [4];
      logic [12:0] exp, got;
      rows = '{row(1,0,0,5'b00000,0), row(1,1,0,5'b00000,0),
               row(0,0,0,5'b00000,0), row(0,0,0,5'b00000,0)};
      foreach (rows[i]) begin
         drive(rows[i]);
         exp = exp_q.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL reset row %0d: got %b required %b", i, got, exp);
         end
      end
   endtask

   task automatic test_rise();
      logic [15:0] rows [9];
      logic [12:0] exp, got;
      rows = '{row(1,0,0,5'b00000,0), row(0,0,0,5'b00000,0), row(0,0,0,5'b00000,0),
               row(0,1,0,5'b11000,1), row(0,0,0,5'b11000,1), row(0,0,0,5'b11000,1),
               row(0,0,0,5'b10000,1), row(0,0,0,5'b10000,1), row(0,1,0,5'b10010,1)};
      foreach (rows[i]) begin
         drive(rows[i]);
         exp = exp_q.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL rise row %0d: got %b required %b", i, got, exp);
         end
      end
   endtask

   task automatic test_pending_fall();
      logic [15:0] rows [8];
      logic [12:0] exp, got;
      rows = '{row(1,0,0,5'b00000,0), row(0,1,0,5'b11000,1), row(0,0,1,5'b11100,1),
               row(0,0,0,5'b11100,1), row(0,0,0,5'b01000,2), row(0,0,0,5'b01000,2),
               row(0,0,0,5'b00000,2), row(0,0,1,5'b00010,2)};
      foreach (rows[i]) begin
         drive(rows[i]);
         exp = exp_q.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL pending_fall row %0d: got %b required %b", i, got, exp);
         end
      end
   endtask

   task automatic test_cancel();
      logic [15:0] rows [7];
      logic [12:0] exp, got;
      rows = '{row(1,0,0,5'b00000,0), row(0,1,0,5'b11000,1), row(0,0,1,5'b11100,1),
               row(0,1,0,5'b11010,1), row(0,0,0,5'b10000,1), row(0,0,0,5'b10000,1),
               row(0,0,0,5'b10000,1)};
      foreach (rows[i]) begin
         drive(rows[i]);
         exp = exp_q.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL cancel row %0d: got %b required %b", i, got, exp);
         end
      end
   endtask

   task automatic test_conflict_drop_reset();
      logic [15:0] rows [11];
      logic [12:0] exp, got;
      rows = '{row(1,0,0,5'b00000,0), row(0,1,1,5'b00001,0), row(0,0,0,5'b00000,0),
               row(0,0,1,5'b00010,0), row(0,0,0,5'b00000,0), row(0,1,0,5'b11000,1),
               row(0,1,1,5'b11001,1), row(1,0,0,5'b00000,0), row(0,1,0,5'b11000,1),
               row(0,0,0,5'b11000,1), row(1,0,1,5'b00000,0)};
      foreach (rows[i]) begin
         drive(rows[i]);
         exp = exp_q.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL conflict_drop_reset row %0d: got %b required %b", i, got, exp);
         end
      end
   endtask

   task automatic test_low_pending();
      logic [15:0] rows [12];
      logic [12:0] exp, got;
      rows = '{row(1,0,0,5'b00000,0), row(0,1,0,5'b11000,1), row(0,0,0,5'b11000,1),
               row(0,0,0,5'b11000,1), row(0,0,0,5'b10000,1), row(0,0,1,5'b01000,2),
               row(0,1,0,5'b01100,2), row(0,0,0,5'b11000,3), row(0,0,0,5'b11000,3),
               row(0,0,0,5'b11000,3), row(0,0,0,5'b10000,3), row(0,1,0,5'b10010,3)};
      foreach (rows[i]) begin
         drive(rows[i]);
         exp = exp_q.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL low_pending row %0d: got %b required %b", i, got, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] rows [9];
      logic [12:0] exp, got;
      // A fall arriving exactly on the expiry cycle flips immediately.
      rows = '{row(1,0,0,5'b00000,0), row(0,1,0,5'b11000,1), row(0,0,0,5'b11000,1),
               row(0,0,0,5'b11000,1), row(0,0,1,5'b01000,2), row(0,0,0,5'b01000,2),
               row(0,1,0,5'b11000,3), row(0,0,1,5'b11100,3), row(0,0,1,5'b11100,3)};
      foreach (rows[i]) begin
         drive(rows[i]);
         exp = exp_q.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL back_to_back row %0d: got %b required %b", i, got, exp);
         end
      end
   endtask

   task automatic test_saturation();
      logic [12:0] exp, got;
      int          gap;
      drive(row(1,0,0,5'b00000,0));
      void'(exp_q.pop_front());
      for (int k = 1; k <= 300; k++) begin
         if (k % 2 == 1) drive(row(0,1,0,5'b11000,(k > 255) ? 255 : k));
         else            drive(row(0,0,1,5'b01000,(k > 255) ? 255 : k));
         exp = exp_q.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL saturation request %0d: got %b required %b", k, got, exp);
         end
         gap = $urandom_range(3, 5);
         for (int j = 0; j < gap; j++) begin
            reset      = 1'b0;
            bus.rise_i = 1'b0;
            bus.fall_i = 1'b0;
            @(posedge clk);
            @(negedge clk);
         end
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset      = 1'b1;
      bus.rise_i = 1'b0;
      bus.fall_i = 1'b0;
      @(negedge clk);
      test_reset();
      test_rise();
      test_pending_fall();
      test_cancel();
      test_conflict_drop_reset();
      test_low_pending();
      test_back_to_back();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
